// File: rtl/qwic51_pkg.sv
// qwic51_pkg: shared bus widths, arbiter state type, master ids and the round-robin pick helper.
package qwic51_pkg;
    localparam int CPU_DATA_WIDTH = 8;
    localparam int CPU_ADDR_WIDTH = 8;
    localparam int ARB_MAX_LOCK   = 16;
    localparam int ARB_M0         = 0;
    localparam int ARB_M1         = 1;

    typedef enum logic [1:0] {ARB_IDLE, ARB_OWN0, ARB_OWN1} arb_state_t;

    // last is the id of the master served most recently; it loses a tie
    function automatic arb_state_t arb_pick(logic req0, logic req1, logic last);
        return (req0 && req1) ? (last ? ARB_OWN0 : ARB_OWN1) :
               req0 ? ARB_OWN0 : req1 ? ARB_OWN1 : ARB_IDLE;
    endfunction
endpackage

// File: rtl/cpu_arb_lock_timer.sv
// cpu_arb_lock_timer: counts consecutive owned cycles and flags a forced release at MAX_LOCK.
module cpu_arb_lock_timer #(
    parameter int MAX_LOCK = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic own,
    input  logic change,
    input  logic other_req,
    output logic timeout
);
    localparam int CW = $clog2(MAX_LOCK + 1);

    logic [CW-1:0] cnt;

    // cnt holds completed owned cycles, so the current cycle is number cnt+1
    assign timeout = own && other_req && (cnt >= CW'(MAX_LOCK - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else
            cnt <= (!own || change) ? '0 : (cnt == CW'(MAX_LOCK)) ? cnt : cnt + 1'b1;
    end
endmodule

// File: rtl/cpu_bus_arb.sv
// cpu_bus_arb: two-master round-robin arbiter for the qwic51 memory bus with locked ownership.
// Optional lock timeout enabled by defining CPU_BUS_ARB_LOCK_LIMIT_EN.
module cpu_bus_arb
    import qwic51_pkg::*;
#(
    parameter int DW       = CPU_DATA_WIDTH,
    parameter int AW       = CPU_ADDR_WIDTH,
    parameter int MAX_LOCK = ARB_MAX_LOCK
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic          M0_REQ,
    input  logic          M1_REQ,
    input  logic          M0_LOCK,
    input  logic          M1_LOCK,
    input  logic [AW-1:0] M0_ADDR,
    input  logic [AW-1:0] M1_ADDR,
    input  logic [DW-1:0] M0_WR_DATA,
    input  logic [DW-1:0] M1_WR_DATA,
    input  logic          M0_WR,
    input  logic          M1_WR,
    input  logic          M0_RD,
    input  logic          M1_RD,
    output logic          M0_GNT,
    output logic          M1_GNT,
    output logic [DW-1:0] M0_RD_DATA,
    output logic [DW-1:0] M1_RD_DATA,
    output logic          M0_RD_VALID,
    output logic          M1_RD_VALID,
    output logic [AW-1:0] MEM_ADDR,
    output logic [DW-1:0] MEM_WR_DATA,
    output logic          MEM_WR,
    output logic          MEM_RD,
    input  logic [DW-1:0] MEM_RD_DATA,
    output logic          LOCK_TO
);
    arb_state_t    state, nxt;
    logic          last, owned, own1, req, lock, wr, rd, other_req, xfer, rel, timeout;
    logic [DW-1:0] rd_data0, rd_data1;

    assign owned     = state != ARB_IDLE;
    assign own1      = state == ARB_OWN1;
    assign req       = own1 ? M1_REQ  : M0_REQ;
    assign lock      = own1 ? M1_LOCK : M0_LOCK;
    assign wr        = own1 ? M1_WR   : M0_WR;
    assign rd        = own1 ? M1_RD   : M0_RD;
    assign other_req = own1 ? M0_REQ  : M1_REQ;

    assign MEM_ADDR    = owned ? (own1 ? M1_ADDR : M0_ADDR) : '0;
    assign MEM_WR_DATA = owned ? (own1 ? M1_WR_DATA : M0_WR_DATA) : '0;
    assign MEM_WR      = owned && wr;
    assign MEM_RD      = owned && rd && !wr;

    assign xfer = owned && (wr || rd);
    assign rel  = owned && (!req || (xfer && !lock) || timeout);
    assign nxt  = (!owned || rel) ? arb_pick(M0_REQ, M1_REQ, last) : state;

    // Return data is forwarded in the valid cycle and then held in the register
    assign M0_RD_DATA = M0_RD_VALID ? MEM_RD_DATA : rd_data0;
    assign M1_RD_DATA = M1_RD_VALID ? MEM_RD_DATA : rd_data1;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= ARB_IDLE;
            last        <= 1'(ARB_M1);
            M0_GNT      <= 1'b0;
            M1_GNT      <= 1'b0;
            M0_RD_VALID <= 1'b0;
            M1_RD_VALID <= 1'b0;
            rd_data0    <= '0;
            rd_data1    <= '0;
        end else begin
            state       <= nxt;
            M0_GNT      <= nxt == ARB_OWN0;
            M1_GNT      <= nxt == ARB_OWN1;
            if (nxt != ARB_IDLE)
                last <= nxt == ARB_OWN1;
            M0_RD_VALID <= MEM_RD && !own1;
            M1_RD_VALID <= MEM_RD && own1;
            rd_data0    <= M0_RD_DATA;
            rd_data1    <= M1_RD_DATA;
        end
    end

`ifdef CPU_BUS_ARB_LOCK_LIMIT_EN
    cpu_arb_lock_timer #(.MAX_LOCK(MAX_LOCK)) u_lock_timer (
        .clk       (CLK),
        .rst_n     (RESET_N),
        .own       (owned),
        .change    (nxt != state),
        .other_req (other_req),
        .timeout   (timeout)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            LOCK_TO <= 1'b0;
        else
            LOCK_TO <= timeout;
    end
`else
    assign timeout = 1'b0;
    assign LOCK_TO = 1'b0;
`endif
endmodule

// File: tb/tb_cpu_bus_arb.sv
// tb_cpu_bus_arb: directed and random checks of cpu_bus_arb against a cycle-level ownership model.
module tb_cpu_bus_arb;
    import qwic51_pkg::*;

    localparam int DW   = 8;
    localparam int AW   = 8;
    localparam int MAXL = 4;
`ifdef CPU_BUS_ARB_LOCK_LIMIT_EN
    localparam bit LIM = 1'b1;
`else
    localparam bit LIM = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RESET_N = 1'b0;
    logic          req[2], lock[2], wr[2], rd[2];
    logic [AW-1:0] addr[2];
    logic [DW-1:0] wdat[2];
    logic [DW-1:0] mem_rd_data;
    logic          M0_GNT, M1_GNT, M0_RD_VALID, M1_RD_VALID, MEM_WR, MEM_RD, LOCK_TO;
    logic [DW-1:0] M0_RD_DATA, M1_RD_DATA, MEM_WR_DATA;
    logic [AW-1:0] MEM_ADDR;

    int total = 0;
    int bad   = 0;

    // model: owner -1 means nobody owns the bus
    int            owner, last, run, pend_m;
    bit            pend, exp_lto;
    logic [DW-1:0] held[2];

    always #5 CLK = ~CLK;

    cpu_bus_arb #(.DW(DW), .AW(AW), .MAX_LOCK(MAXL)) dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .M0_REQ      (req[0]),
        .M1_REQ      (req[1]),
        .M0_LOCK     (lock[0]),
        .M1_LOCK     (lock[1]),
        .M0_ADDR     (addr[0]),
        .M1_ADDR     (addr[1]),
        .M0_WR_DATA  (wdat[0]),
        .M1_WR_DATA  (wdat[1]),
        .M0_WR       (wr[0]),
        .M1_WR       (wr[1]),
        .M0_RD       (rd[0]),
        .M1_RD       (rd[1]),
        .M0_GNT      (M0_GNT),
        .M1_GNT      (M1_GNT),
        .M0_RD_DATA  (M0_RD_DATA),
        .M1_RD_DATA  (M1_RD_DATA),
        .M0_RD_VALID (M0_RD_VALID),
        .M1_RD_VALID (M1_RD_VALID),
        .MEM_ADDR    (MEM_ADDR),
        .MEM_WR_DATA (MEM_WR_DATA),
        .MEM_WR      (MEM_WR),
        .MEM_RD      (MEM_RD),
        .MEM_RD_DATA (mem_rd_data),
        .LOCK_TO     (LOCK_TO)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int pick();
        if (req[0] && req[1])
            return (last == 1) ? 0 : 1;
        return req[0] ? 0 : req[1] ? 1 : -1;
    endfunction

    task automatic clear_inputs();
        for (int m = 0; m < 2; m++) begin
            req[m] = 0; lock[m] = 0; wr[m] = 0; rd[m] = 0; addr[m] = '0; wdat[m] = '0;
        end
        mem_rd_data = '0;
    endtask

    task automatic model_reset();
        owner = -1; last = 1; run = 0; pend = 0; pend_m = -1; exp_lto = 0;
        held[0] = '0; held[1] = '0;
    endtask

    // Called at a negedge with inputs already applied; returns at the next negedge
    task automatic tick(input string tag);
        int            o, nw;
        bit            ewr, erd, xfer, to;
        bit            ev[2];
        logic [AW-1:0] ea;
        logic [DW-1:0] ewd;
        logic [DW-1:0] ed[2];
        #1;
        o   = owner;
        ewr = (o >= 0) && wr[o];
        erd = (o >= 0) && rd[o] && !wr[o];
        ea  = (o >= 0) ? addr[o] : '0;
        ewd = (o >= 0) ? wdat[o] : '0;
        for (int m = 0; m < 2; m++) begin
            ev[m] = pend && pend_m == m;
            ed[m] = ev[m] ? mem_rd_data : held[m];
        end
        chk({tag, ".ctl"}, {M0_GNT, M1_GNT, MEM_WR, MEM_RD, M0_RD_VALID, M1_RD_VALID, LOCK_TO},
            {o == 0, o == 1, ewr, erd, ev[0], ev[1], exp_lto});
        chk({tag, ".bus"}, {MEM_ADDR, MEM_WR_DATA}, {ea, ewd});
        chk({tag, ".rdd"}, {M0_RD_DATA, M1_RD_DATA}, {ed[0], ed[1]});
        @(posedge CLK);
        if (RESET_N) begin
            held[0] = ed[0];
            held[1] = ed[1];
            pend    = erd;
            pend_m  = o;
            exp_lto = 0;
            nw      = o;
            if (o < 0)
                nw = pick();
            else begin
                xfer = wr[o] || rd[o];
                to   = LIM && run >= MAXL && req[1-o];
                if (!req[o] || (xfer && !lock[o]) || to) begin
                    nw      = pick();
                    exp_lto = to;
                end
            end
            run = (nw < 0) ? 0 : (nw == o) ? run + 1 : 1;
            if (nw >= 0)
                last = nw;
            owner = nw;
        end
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RESET_N = 0;
        clear_inputs();
        model_reset();
        tick("reset");
        RESET_N = 1;
    endtask

    initial begin
        clear_inputs();
        model_reset();
        do_reset();
        chk("reset_gnt", {M0_GNT, M1_GNT}, 2'b00);

        // single request from M1
        req[1] = 1;
        tick("single_c0");
        chk("single_gnt", {M0_GNT, M1_GNT}, 2'b01);
        wr[1] = 1; addr[1] = 8'h90; wdat[1] = 8'h5A; req[1] = 0;
        #1 chk("single_bus", {MEM_WR, MEM_ADDR, MEM_WR_DATA}, {1'b1, 8'h90, 8'h5A});
        tick("single_c1");
        wr[1] = 0;
        chk("single_release", {M0_GNT, M1_GNT}, 2'b00);
        tick("single_c2");

        // tie after reset, then alternation with no idle gap
        do_reset();
        req[0] = 1; req[1] = 1;
        tick("tie_c0");
        chk("tie_first", {M0_GNT, M1_GNT}, 2'b10);
        wr[0] = 1; addr[0] = 8'h11; wdat[0] = 8'h22;
        tick("tie_c1");
        chk("tie_handover", {M0_GNT, M1_GNT}, 2'b01);
        wr[0] = 0; wr[1] = 1; addr[1] = 8'h33; wdat[1] = 8'h44;
        tick("tie_c2");
        chk("tie_back", {M0_GNT, M1_GNT}, 2'b10);

        // WR+RD together from owner, strobes from the ungranted master
        wr[1] = 1; rd[1] = 1; addr[1] = 8'hEE;
        wr[0] = 1; rd[0] = 1; addr[0] = 8'h55; wdat[0] = 8'h66; lock[0] = 1;
        #1 chk("illegal_strobes", {MEM_WR, MEM_RD, MEM_ADDR}, {2'b10, 8'h55});
        tick("illegal");
        wr[0] = 0; rd[0] = 0; wr[1] = 0; rd[1] = 0; lock[0] = 0;

        // read return across handover
        do_reset();
        req[0] = 1;
        tick("rdh_c0");
        rd[0] = 1; addr[0] = 8'h30; req[1] = 1;
        tick("rdh_c1");
        chk("rdh_gnt", {M0_GNT, M1_GNT}, 2'b01);
        chk("rdh_valid", {M0_RD_VALID, M1_RD_VALID}, 2'b10);
        rd[0] = 0; req[0] = 0; mem_rd_data = 8'hC3;
        #1 chk("rdh_data", M0_RD_DATA, 8'hC3);
        tick("rdh_c2");
        mem_rd_data = 8'h00;
        chk("rdh_hold_valid", {M0_RD_VALID, M1_RD_VALID}, 2'b00);
        #1 chk("rdh_hold_data", M0_RD_DATA, 8'hC3);
        tick("rdh_c3");

        // lock: M0 keeps the bus through several transfers while M1 waits
        do_reset();
        req[0] = 1;
        tick("lock_c0");
        lock[0] = 1; wr[0] = 1; req[1] = 1;
        for (int i = 0; i < 3; i++) begin
            addr[0] = 8'(i); wdat[0] = 8'(i + 8'h10);
            tick("lock_xfer");
            chk("lock_hold", M1_GNT, 1'b0);
        end
        tick("lock_xfer4");
        chk("lock_fourth", M1_GNT, LIM);
        lock[0] = 0;
        tick("lock_drop");
        chk("lock_release", {M0_GNT, M1_GNT}, 2'b01);
        wr[0] = 0; req[1] = 0;
        tick("lock_end");

        // lock held for 10 cycles with M1 waiting
        do_reset();
        req[0] = 1; lock[0] = 1; wr[0] = 1; req[1] = 1;
        for (int i = 0; i < 10; i++)
            tick("lock_long");
        clear_inputs();
        tick("lock_long_end");

        // reset asserted in the same cycle as MEM_RD
        do_reset();
        req[0] = 1;
        tick("rst_c0");
        rd[0] = 1; addr[0] = 8'h44;
        #1 chk("rst_rd_live", MEM_RD, 1'b1);
        RESET_N = 0;
        #1;
        chk("rst_ctl", {M0_GNT, M1_GNT, MEM_WR, MEM_RD, M0_RD_VALID, M1_RD_VALID, LOCK_TO}, 7'd0);
        chk("rst_bus", {MEM_ADDR, MEM_WR_DATA, M0_RD_DATA, M1_RD_DATA}, 32'd0);
        clear_inputs();
        model_reset();
        @(posedge CLK);
        @(negedge CLK);
        RESET_N = 1;
        tick("rst_after0");
        chk("rst_no_return", {M0_RD_VALID, M1_RD_VALID}, 2'b00);
        tick("rst_after1");

        // random traffic
        do_reset();
        for (int n = 0; n < 400; n++) begin
            for (int m = 0; m < 2; m++) begin
                req[m]  = $urandom_range(0, 9) < 7;
                lock[m] = $urandom_range(0, 9) < 2;
                wr[m]   = $urandom_range(0, 3) == 0;
                rd[m]   = $urandom_range(0, 2) == 0;
                addr[m] = 8'($urandom);
                wdat[m] = 8'($urandom);
            end
            mem_rd_data = 8'($urandom);
            tick("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
